memory_stage: RTL and testbench

// - Memory (M) stage of the 5-stage RV32I pipeline, directly upstream of the writeback stage.
// - Owns the Execute->Memory pipeline register, with stall and flush.
// - Owns the byte-addressable data memory and the load/store unit (LB/LH/LW/LBU/LHU/SB/SH/SW).
// - Presents M-stage values to writeback: RegWriteM, ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/memory_stage_if.sv | 36 +++
 rtl/memory_stage_data_mem.sv | 29 ++
 rtl/memory_stage.sv | 149 ++++++++++++++
 tb/tb_memory_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the memory stage: funct3 encodings, result
// select values and small load/store decode helpers.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    // Byte lanes touched by a store of the given size at the given lane.
    function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << lane;
            F3_SH:   be = 4'b0011 << lane;
            F3_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across the word so every lane sees its byte.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            F3_SB:   d = {4{wd[7:0]}};
            F3_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Half-word accesses need an even lane, word accesses need lane 0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic half;
        logic word;
        half = (f3[1:0] == 2'b01);
        word = (f3[1:0] == 2'b10);
        return (half & lane[0]) | (word & (lane != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute->Memory inputs, hazard controls and Memory->Writeback outputs.
interface memory_stage_if #(parameter int WIDTH = 32);

    logic             StallM;
    logic             FlushM;
    logic             RegWriteE;
    logic [1:0]       ResultSrcE;
    logic             MemWriteE;
    logic             MemReadE;
    logic [2:0]       Funct3E;
    logic [WIDTH-1:0] ALUResultE;
    logic [WIDTH-1:0] WriteDataE;
    logic [4:0]       RdE;
    logic [WIDTH-1:0] PCPlus4E;

    logic             RegWriteM;
    logic [1:0]       ResultSrcM;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] ReadDataM;
    logic [4:0]       RdM;
    logic [WIDTH-1:0] PCPlus4M;
    logic             MisalignM;

    modport master (
        output StallM, FlushM, RegWriteE, ResultSrcE, MemWriteE, MemReadE,
               Funct3E, ALUResultE, WriteDataE, RdE, PCPlus4E,
        input  RegWriteM, ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M, MisalignM
    );

    modport slave (
        input  StallM, FlushM, RegWriteE, ResultSrcE, MemWriteE, MemReadE,
               Funct3E, ALUResultE, WriteDataE, RdE, PCPlus4E,
        output RegWriteM, ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M, MisalignM
    );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Word-organised data memory: byte-enable synchronous write, async read.
// Contents are deliberately not reset.
module data_mem #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-3:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write each enabled byte lane of the addressed word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the RV32I pipeline: E->M pipeline register with
// stall/flush, load/store unit and data memory.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);

    logic             reg_write_r;
    logic [1:0]       result_src_r;
    logic             mem_write_r;
    logic             mem_read_r;
    logic [2:0]       funct3_r;
    logic [WIDTH-1:0] alu_result_r;
    logic [WIDTH-1:0] write_data_r;
    logic [4:0]       rd_r;
    logic [WIDTH-1:0] pc_plus4_r;

    logic [1:0]       lane_s;
    logic             load_f3_ok_s;
    logic             store_f3_ok_s;
    logic             access_s;
    logic             misalign_s;
    logic             load_ok_s;
    logic [3:0]       byte_en_s;
    logic [WIDTH-1:0] mem_rdata_s;
    logic [7:0]       byte_s;
    logic [15:0]      half_s;
    logic [WIDTH-1:0] read_data_s;

    // E->M pipeline register: reset, then flush (bubble), then stall (hold).
    always_ff @(posedge clk) begin
        if (rst || bus.FlushM) begin
            reg_write_r  <= 1'b0;
            result_src_r <= 2'b00;
            mem_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            funct3_r     <= 3'b000;
            alu_result_r <= '0;
            write_data_r <= '0;
            rd_r         <= 5'd0;
            pc_plus4_r   <= '0;
        end else if (!bus.StallM) begin
            reg_write_r  <= bus.RegWriteE;
            result_src_r <= bus.ResultSrcE;
            mem_write_r  <= bus.MemWriteE;
            mem_read_r   <= bus.MemReadE;
            funct3_r     <= bus.Funct3E;
            alu_result_r <= bus.ALUResultE;
            write_data_r <= bus.WriteDataE;
            rd_r         <= bus.RdE;
            pc_plus4_r   <= bus.PCPlus4E;
        end
    end

    assign lane_s = alu_result_r[1:0];

    // Classify funct3 as a legal load and/or store encoding; others are no-ops.
    always_comb begin
        load_f3_ok_s  = 1'b0;
        store_f3_ok_s = 1'b0;
        case (funct3_r)
            F3_LB, F3_LH, F3_LW: begin
                load_f3_ok_s  = 1'b1;
                store_f3_ok_s = 1'b1;
            end
            F3_LBU, F3_LHU: begin
                load_f3_ok_s  = 1'b1;
                store_f3_ok_s = 1'b0;
            end
            default: begin
                load_f3_ok_s  = 1'b0;
                store_f3_ok_s = 1'b0;
            end
        endcase
    end

    assign access_s   = (mem_read_r & load_f3_ok_s) | (mem_write_r & store_f3_ok_s);
    assign misalign_s = access_s & is_misaligned(funct3_r, lane_s);
    assign load_ok_s  = mem_read_r & load_f3_ok_s & ~misalign_s;

    // Store byte enables; reset suppresses a store sitting in M.
    always_comb begin
        byte_en_s = 4'b0000;
        if (mem_write_r && store_f3_ok_s && !misalign_s && !rst) begin
            byte_en_s = store_byte_en(funct3_r, lane_s);
        end else begin
            byte_en_s = 4'b0000;
        end
    end

    data_mem #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_data_mem (
        .clk   (clk),
        .we    (byte_en_s),
        .addr  (alu_result_r[ADDR_WIDTH-1:2]),
        .wdata (store_data(funct3_r, write_data_r)),
        .rdata (mem_rdata_s)
    );

    // Pick the addressed byte and half-word out of the read word.
    always_comb begin
        byte_s = 8'h00;
        case (lane_s)
            2'd0:    byte_s = mem_rdata_s[7:0];
            2'd1:    byte_s = mem_rdata_s[15:8];
            2'd2:    byte_s = mem_rdata_s[23:16];
            default: byte_s = mem_rdata_s[31:24];
        endcase
        if (lane_s[1]) begin
            half_s = mem_rdata_s[31:16];
        end else begin
            half_s = mem_rdata_s[15:0];
        end
    end

    // Extend the loaded value; anything that is not a good load reads as zero.
    always_comb begin
        read_data_s = '0;
        if (load_ok_s) begin
            case (funct3_r)
                F3_LB:   read_data_s = {{(WIDTH-8){byte_s[7]}}, byte_s};
                F3_LH:   read_data_s = {{(WIDTH-16){half_s[15]}}, half_s};
                F3_LW:   read_data_s = mem_rdata_s;
                F3_LBU:  read_data_s = {{(WIDTH-8){1'b0}}, byte_s};
                F3_LHU:  read_data_s = {{(WIDTH-16){1'b0}}, half_s};
                default: read_data_s = '0;
            endcase
        end else begin
            read_data_s = '0;
        end
    end

    assign bus.RegWriteM  = reg_write_r & ~(mem_read_r & misalign_s);
    assign bus.ResultSrcM = result_src_r;
    assign bus.ALUResultM = alu_result_r;
    assign bus.ReadDataM  = read_data_s;
    assign bus.RdM        = rd_r;
    assign bus.PCPlus4M   = pc_plus4_r;
    assign bus.MisalignM  = misalign_s;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a byte-level reference model.
module tb_memory_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    bit   checks_on = 1'b0;
    logic [31:0] pc_cnt = 32'h0000_1000;

    memory_stage_if #(.WIDTH(32)) bus ();

    memory_stage #(.WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        mr;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
    } slot_t;

    slot_t      m_q = '0;
    logic [7:0] mem_model [4096];
    bit         known     [4096];

    function automatic int acc_bytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit is_load(input logic [2:0] f3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic bit is_store(input logic [2:0] f3);
        return f3 <= 3'd2;
    endfunction

    function automatic bit model_mis(input slot_t s);
        int a;
        bit acc;
        a   = int'(s.alu[11:0]);
        acc = (s.mr && is_load(s.f3)) || (s.mw && is_store(s.f3));
        return acc && ((a % acc_bytes(s.f3)) != 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commit the store in M, then advance the M slot.
    always @(posedge clk) begin
        if (!rst && m_q.mw && is_store(m_q.f3) && !model_mis(m_q)) begin
            for (int k = 0; k < acc_bytes(m_q.f3); k++) begin
                mem_model[(int'(m_q.alu[11:0]) + k) % 4096] <= m_q.wd[8*k +: 8];
                known[(int'(m_q.alu[11:0]) + k) % 4096]     <= 1'b1;
            end
        end
        if (rst || bus.FlushM) begin
            m_q <= '0;
        end else if (!bus.StallM) begin
            m_q <= '{bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.MemReadE, bus.Funct3E,
                     bus.ALUResultE, bus.WriteDataE, bus.RdE, bus.PCPlus4E};
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (checks_on) begin
            bit          mis;
            bit          all_known;
            logic [31:0] exp_rd;
            int          n;
            int          a;
            mis       = model_mis(m_q);
            exp_rd    = 32'h0;
            all_known = 1'b1;
            if (m_q.mr && is_load(m_q.f3) && !mis) begin
                n = acc_bytes(m_q.f3);
                a = int'(m_q.alu[11:0]);
                for (int k = 0; k < n; k++) begin
                    exp_rd[8*k +: 8] = mem_model[(a + k) % 4096];
                    if (!known[(a + k) % 4096]) all_known = 1'b0;
                end
                if (!m_q.f3[2] && n == 1) exp_rd[31:8]  = {24{exp_rd[7]}};
                if (!m_q.f3[2] && n == 2) exp_rd[31:16] = {16{exp_rd[15]}};
            end
            chk("RegWriteM",  {31'd0, bus.RegWriteM}, {31'd0, m_q.rw & ~(m_q.mr & mis)});
            chk("ResultSrcM", {30'd0, bus.ResultSrcM}, {30'd0, m_q.rs});
            chk("ALUResultM", bus.ALUResultM, m_q.alu);
            chk("RdM",        {27'd0, bus.RdM}, {27'd0, m_q.rd});
            chk("PCPlus4M",   bus.PCPlus4M, m_q.pc);
            chk("MisalignM",  {31'd0, bus.MisalignM}, {31'd0, mis});
            if (all_known) chk("ReadDataM", bus.ReadDataM, exp_rd);
        end
    end

    task automatic issue(input logic rw, input logic [1:0] rs, input logic mw, input logic mr,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        bus.RegWriteE  = rw;
        bus.ResultSrcE = rs;
        bus.MemWriteE  = mw;
        bus.MemReadE   = mr;
        bus.Funct3E    = f3;
        bus.ALUResultE = addr;
        bus.WriteDataE = wd;
        bus.RdE        = rd;
        bus.PCPlus4E   = pc_cnt;
        pc_cnt         = pc_cnt + 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(1'b0, 2'b00, 1'b1, 1'b0, f3, addr, wd, 5'd0);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        issue(1'b1, 2'b01, 1'b0, 1'b1, f3, addr, 32'd0, rd);
    endtask

    task automatic alu_op(input logic [31:0] val, input logic [4:0] rd);
        issue(1'b1, 2'b00, 1'b0, 1'b0, 3'd0, val, 32'd0, rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.StallM = 1'b0;
        bus.FlushM = 1'b0;
        rst = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 1'b0, 3'd2, 32'h1234, 32'h1, 5'd3);
        issue(1'b1, 2'b10, 1'b0, 1'b0, 3'd2, 32'h1234, 32'h1, 5'd3);
        checks_on = 1'b1;
        chk("reset_RegWriteM", {31'd0, bus.RegWriteM}, 32'd0);
        chk("reset_ALUResultM", bus.ALUResultM, 32'd0);
        chk("reset_RdM", {27'd0, bus.RdM}, 32'd0);
        chk("reset_PCPlus4M", bus.PCPlus4M, 32'd0);
        rst = 1'b0;

        st(F3_SW, 32'h010, 32'hDEAD_BEEF);
        ld(F3_LW, 32'h010, 5'd1);
        chk("lw_010", bus.ReadDataM, 32'hDEAD_BEEF);
        chk("lw_010_src", {30'd0, bus.ResultSrcM}, 32'd1);
        st(F3_SB, 32'h013, 32'h0000_0080);
        ld(F3_LB, 32'h013, 5'd2);
        chk("lb_013", bus.ReadDataM, 32'hFFFF_FF80);
        ld(F3_LBU, 32'h013, 5'd2);
        chk("lbu_013", bus.ReadDataM, 32'h0000_0080);
        ld(F3_LW, 32'h010, 5'd2);
        chk("lw_010_b", bus.ReadDataM, 32'h80AD_BEEF);
        ld(F3_LH, 32'h012, 5'd4);
        chk("lh_012", bus.ReadDataM, 32'hFFFF_80AD);
        ld(F3_LHU, 32'h012, 5'd4);
        chk("lhu_012", bus.ReadDataM, 32'h0000_80AD);

        st(F3_SW, 32'h020, 32'h0);
        st(F3_SH, 32'h022, 32'h0000_1234);
        ld(F3_LW, 32'h020, 5'd5);
        chk("lw_020", bus.ReadDataM, 32'h1234_0000);
        ld(F3_LH, 32'h021, 5'd5);
        chk("lh_021_mis", {31'd0, bus.MisalignM}, 32'd1);
        chk("lh_021_data", bus.ReadDataM, 32'd0);
        chk("lh_021_rw", {31'd0, bus.RegWriteM}, 32'd0);

        st(F3_SW, 32'h1004, 32'hCAFE_F00D);
        ld(F3_LW, 32'h004, 5'd6);
        chk("lw_wrap", bus.ReadDataM, 32'hCAFE_F00D);

        st(F3_SW, 32'h030, 32'h1111_1111);
        st(F3_SW, 32'h031, 32'h2222_2222);
        chk("sw_031_mis", {31'd0, bus.MisalignM}, 32'd1);
        st(F3_SH, 32'h033, 32'h3333_3333);
        st(3'd3, 32'h030, 32'h4444_4444);
        issue(1'b1, 2'b01, 1'b0, 1'b1, 3'd6, 32'h031, 32'd0, 5'd7);
        chk("inv_f3_data", bus.ReadDataM, 32'd0);
        chk("inv_f3_mis", {31'd0, bus.MisalignM}, 32'd0);
        ld(F3_LW, 32'h030, 5'd7);
        chk("lw_030", bus.ReadDataM, 32'h1111_1111);

        alu_op(32'h55, 5'd5);
        bus.StallM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_op(32'h60 + i, 5'd10 + 5'(i));
            chk("stall_rd", {27'd0, bus.RdM}, 32'd5);
        end
        bus.StallM = 1'b0;

        st(F3_SW, 32'h050, 32'h1234_5678);
        bus.FlushM = 1'b1;
        st(F3_SW, 32'h050, 32'h9999_9999);
        bus.FlushM = 1'b0;
        chk("flush_rd", {27'd0, bus.RdM}, 32'd0);
        ld(F3_LW, 32'h050, 5'd8);
        chk("flush_nostore", bus.ReadDataM, 32'h1234_5678);

        st(F3_SW, 32'h060, 32'h5A5A_5A5A);
        st(F3_SW, 32'h060, 32'hAAAA_AAAA);
        rst = 1'b1;
        alu_op(32'h77, 5'd9);
        rst = 1'b0;
        chk("rst_alu", bus.ALUResultM, 32'd0);
        chk("rst_pc", bus.PCPlus4M, 32'd0);
        ld(F3_LW, 32'h060, 5'd9);
        chk("rst_nostore", bus.ReadDataM, 32'h5A5A_5A5A);

        alu_op(32'h88, 5'd9);
        bus.StallM = 1'b1;
        bus.FlushM = 1'b1;
        alu_op(32'h99, 5'd10);
        bus.StallM = 1'b0;
        bus.FlushM = 1'b0;
        chk("stall_flush_rd", {27'd0, bus.RdM}, 32'd0);
        chk("stall_flush_rw", {31'd0, bus.RegWriteM}, 32'd0);

        alu_op(32'h0, 5'd0);
        @(negedge clk);
        checks_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
